seq_divider: RTL
================

Name: seq_divider

Overview:
Iterative radix-2 restoring divider, the division counterpart to the Booth multiplier in the RV32IM M-extension datapath. It serves DIV, DIVU, REM and REMU, producing quotient and remainder together. The execute stage starts an operation with a one-cycle start pulse, stalls while busy is high, and consumes results on the done pulse.

Parameters:
N, 32, operand width in bits; also the iteration count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
is_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU
dividend  input  N  numerator, latched on accepted start
divisor  input  N  denominator, latched on accepted start
quotient  output  N  registered quotient, held until next done
remainder  output  N  registered remainder, held until next done
busy  output  1  high from the accepted-start edge until the cycle done is high, inclusive
done  output  1  one-cycle pulse; quotient/remainder valid in that cycle and held afterwards

Behaviour:
- Reset (async, rst_n low): state=IDLE, quotient=0, remainder=0, busy=0, done=0, internal registers cleared. Reset mid-operation aborts it; no done is issued.
- States: IDLE, RUN, DONE (2-bit enum).
- IDLE: start=1 at edge E0 latches operands and is_signed, computes operand magnitudes, clears the partial remainder, sets count=0, busy=1, and moves to RUN. start=0 keeps the block in IDLE.
- RUN: one iteration per edge:
  - shift {partial remainder, quotient register} left by 1;
  - trial-subtract |divisor| using an N+1-bit subtraction;
  - if the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
- At edge EN (the Nth iteration), apply sign fix-up and special cases, register quotient and remainder, set done=1, and go to DONE.
- DONE: at edge EN+1, done=0, busy=0, state=IDLE.
- Latency: done is high in the cycle after EN, i.e. N cycles after the start-sampling edge. A new start is accepted in the first IDLE cycle after that.
- start while busy is ignored and not queued. Input changes after E0 have no effect.
- Signed fix-up:
  - quotient is negated when dividend and divisor signs differ;
  - remainder takes the dividend's sign;
  - magnitudes use N-bit two's complement, so |-2^(N-1)| = 2^(N-1) is correct as an unsigned value.
- Divide by zero (either signedness): quotient = all ones, remainder = dividend.
- Signed overflow (dividend = 0x8000_0000, divisor = -1, is_signed=1): quotient = dividend, remainder = 0.
- Both special cases are detected at E0 and override the iterative result.
- Unsigned mode performs no sign handling; the full N-bit range is valid.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed overflow skip RUN. At E0 the state goes to DONE with results registered, so done is high in the cycle after E0 (1-cycle latency). Normal operations are unchanged.
- Not defined: every operation takes exactly N cycles, including special cases. Latency is fixed and data-independent.

Decomposition:
- Package div_pkg holds:
  - the state_t enum (IDLE, RUN, DONE);
  - localparams for the special-case constants: all-ones quotient and the signed minimum value.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder (N bits), next dividend bit, |divisor|.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once in the RUN datapath.

Test Plan:
- Unsigned 100 / 7 (is_signed=0) -> quotient=14, remainder=2; done exactly N cycles after the start edge; busy high throughout.
- Signed -7 / 2 -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1). Signed 7 / -2 -> quotient=0xFFFF_FFFD, remainder=1.
- Divide by zero: 5 / 0 in both modes -> quotient=0xFFFF_FFFF, remainder=5. Latency is N, or 1 with DIV_EARLY_OUT_EN.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x8000_0000.
- start pulsed again at cycle 5 of an operation with different operands -> ignored; first result unchanged; single done pulse.
- rst_n asserted at cycle 10 of an operation -> outputs 0, no done. A fresh 0xFFFF_FFFF / 1 unsigned after reset -> quotient=0xFFFF_FFFF, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient returned on divide by zero
  localparam logic [DIV_N-1:0] QUO_ALL_ONES = '1;
  // Most negative signed value; dividend half of the signed-overflow case
  localparam logic [DIV_N-1:0] SIGNED_MIN   = {1'b1, {(DIV_N-1){1'b0}}};

  // Operand magnitude; negation wraps so |SIGNED_MIN| reads as 2^(N-1) unsigned
  function automatic logic [DIV_N-1:0] abs_mag(input logic [DIV_N-1:0] x,
                                               input logic             sgn);
    return (sgn && x[DIV_N-1]) ? (~x + DIV_N'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_dvsr,
  output logic [N-1:0] o_rem_c,
  output logic         o_qbit_c
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;

  // Shift in the next dividend bit and trial-subtract the divisor magnitude
  assign w_shift  = {i_rem, i_bit};
  assign w_diff   = w_shift - {1'b0, i_dvsr};

  // Non-negative difference keeps the subtraction, otherwise restore
  assign o_qbit_c = ~w_diff[N];
  assign o_rem_c  = w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// bypass the iteration and complete one cycle after start.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done
);

  localparam int unsigned     CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [N-1:0]     r_dividend;
  logic [N-1:0]     r_dvsr_mag;
  logic [N-1:0]     r_rem;
  logic [N-1:0]     r_quo;
  logic [CNT_W-1:0] r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic             r_ovf;

  logic [N-1:0]     r_quotient;
  logic [N-1:0]     r_remainder;
  logic             r_busy;
  logic             r_done;

  logic [N-1:0]     w_quotient_nxt;
  logic [N-1:0]     w_remainder_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [N-1:0]     w_dvd_mag;
  logic [N-1:0]     w_dvs_mag;
  logic [N-1:0]     w_step_rem;
  logic             w_step_qbit;
  logic [N-1:0]     w_quo_mag;
  logic [N-1:0]     w_quo_fin;
  logic [N-1:0]     w_rem_fin;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_last;

  // Operand classification done on the incoming operands at the start edge
  assign w_dvd_mag  = abs_mag(dividend, is_signed);
  assign w_dvs_mag  = abs_mag(divisor, is_signed);
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = is_signed && (dividend == SIGNED_MIN) && (divisor == QUO_ALL_ONES);
  assign w_last     = (r_count == LAST_CNT);

`ifdef DIV_EARLY_OUT_EN
  logic         w_early;
  logic [N-1:0] w_early_quo;
  logic [N-1:0] w_early_rem;

  // Special-case results available straight from the inputs
  assign w_early     = w_div_zero | w_ovf;
  assign w_early_quo = w_div_zero ? QUO_ALL_ONES : dividend;
  assign w_early_rem = w_div_zero ? dividend : '0;
`endif

  // Single restoring iteration; MSB of the quotient register feeds in next
  div_step #(.N(N)) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[N-1]),
    .i_dvsr   (r_dvsr_mag),
    .o_rem_c  (w_step_rem),
    .o_qbit_c (w_step_qbit)
  );

  assign w_quo_mag = {r_quo[N-2:0], w_step_qbit};

  // Sign fix-up of the final iteration, overridden by the special cases
  always_comb begin
    w_quo_fin = r_neg_q ? (~w_quo_mag + N'(1)) : w_quo_mag;
    w_rem_fin = r_neg_r ? (~w_step_rem + N'(1)) : w_step_rem;
    if (r_div_zero) begin
      w_quo_fin = QUO_ALL_ONES;
      w_rem_fin = r_dividend;
    end else if (r_ovf) begin
      w_quo_fin = r_dividend;
      w_rem_fin = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_nxt = w_early ? DONE : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake and result outputs
  always_comb begin
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_busy_nxt = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          if (w_early) begin
            w_done_nxt      = 1'b1;
            w_quotient_nxt  = w_early_quo;
            w_remainder_nxt = w_early_rem;
          end
`endif
        end
      end
      RUN: begin
        if (w_last) begin
          w_done_nxt      = 1'b1;
          w_quotient_nxt  = w_quo_fin;
          w_remainder_nxt = w_rem_fin;
        end
      end
      DONE:    w_busy_nxt = 1'b0;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
    end
  end

  // Iteration datapath: operand capture on accept, one shift/subtract per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_dvsr_mag <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_count    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_dvsr_mag <= w_dvs_mag;
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_count    <= '0;
            r_neg_q    <= is_signed && (dividend[N-1] ^ divisor[N-1]);
            r_neg_r    <= is_signed && dividend[N-1];
            r_div_zero <= w_div_zero;
            r_ovf      <= w_ovf;
          end
        end
        RUN: begin
          r_rem   <= w_step_rem;
          r_quo   <= w_quo_mag;
          r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
